// File: rtl/relax_pkg.sv
// -----------------------------------------------------------------------------
// relax_pkg
// Shared definitions for the edge-relaxation controller.
//   state_t  : FSM state encoding used by relax_ctrl.
//   dist_inf : all-ones "infinite distance" value for a given word width.
// Optional feature macro consumed by relax_ctrl: RELAX_CTRL_INF_SKIP_EN.
// -----------------------------------------------------------------------------
package relax_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PROC  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // All-ones value of the requested width (up to 64 bits), right-aligned.
  function automatic logic [63:0] dist_inf(input int width);
    return {64{1'b1}} >> (64 - width);
  endfunction

endpackage

// File: rtl/relax_ctrl_process_node.sv
// -----------------------------------------------------------------------------
// process_node
// Purely combinational relaxation of all neighbour slots of one node.
//   dist_node_in      : distance of the node being relaxed
//   custo_vizinhos_in : packed edge costs, slot i at [CUSTO_WIDTH*i +: CUSTO_WIDTH]
//   dist_vizinhos_in  : packed current neighbour distances
//   update_out        : slot i would get a strictly shorter distance
//   nova_dist_out     : packed candidate distances (node distance + cost)
// The adder is DIST_WIDTH wide and wraps modulo 2**DIST_WIDTH; costs wider than
// DIST_WIDTH are truncated. An infinite node distance therefore produces small
// wrapped candidates unless the caller suppresses them.
// -----------------------------------------------------------------------------
module process_node
  import relax_pkg::*;
#(
  parameter int DIST_WIDTH   = 8,
  parameter int CUSTO_WIDTH  = 8,
  parameter int NUM_VIZINHOS = 8
) (
  input  logic [DIST_WIDTH-1:0]              dist_node_in,
  input  logic [CUSTO_WIDTH*NUM_VIZINHOS-1:0] custo_vizinhos_in,
  input  logic [DIST_WIDTH*NUM_VIZINHOS-1:0]  dist_vizinhos_in,
  output logic [NUM_VIZINHOS-1:0]             update_out,
  output logic [DIST_WIDTH*NUM_VIZINHOS-1:0]  nova_dist_out
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VIZINHOS; gi++) begin : g_slot
      logic [DIST_WIDTH-1:0] custo_ext;
      logic [DIST_WIDTH-1:0] nova;
      assign custo_ext = DIST_WIDTH'(custo_vizinhos_in[gi*CUSTO_WIDTH +: CUSTO_WIDTH]);
      assign nova      = dist_node_in + custo_ext;
      assign nova_dist_out[gi*DIST_WIDTH +: DIST_WIDTH] = nova;
      assign update_out[gi] = (nova < dist_vizinhos_in[gi*DIST_WIDTH +: DIST_WIDTH]);
    end
  endgenerate

endmodule

// File: rtl/relax_ctrl.sv
// -----------------------------------------------------------------------------
// relax_ctrl
// Relaxes every neighbour of one node: reads the node and neighbour distances
// from an external distance memory, evaluates them in process_node, then writes
// each improved distance back while offering the neighbour id to a frontier sink.
//
// Ports
//   clk, rst (sync, active high)
//   start_in / node_id_in / vizinho_id_in / vizinho_valid_in / custo_vizinhos_in
//       : request, captured in IDLE only
//   mem_rd_en_out / mem_rd_addr_out / mem_rd_data_in
//       : distance reads, data returned one cycle after the strobe
//   mem_wr_en_out / mem_wr_addr_out / mem_wr_data_out : distance write-back
//   frontier_valid_out / frontier_id_out / frontier_ready_in : updated ids
//   busy_out (not IDLE), done_out (one-cycle completion pulse)
//
// Optional feature: define RELAX_CTRL_INF_SKIP_EN to skip all updates when the
// node's own distance is infinite (all ones).
// -----------------------------------------------------------------------------
module relax_ctrl
  import relax_pkg::*;
#(
  parameter int DIST_WIDTH   = 8,
  parameter int CUSTO_WIDTH  = 8,
  parameter int NUM_VIZINHOS = 8,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_in,
  input  logic [ADDR_WIDTH-1:0]               node_id_in,
  input  logic [ADDR_WIDTH*NUM_VIZINHOS-1:0]  vizinho_id_in,
  input  logic [NUM_VIZINHOS-1:0]             vizinho_valid_in,
  input  logic [CUSTO_WIDTH*NUM_VIZINHOS-1:0] custo_vizinhos_in,
  output logic                                mem_rd_en_out,
  output logic [ADDR_WIDTH-1:0]               mem_rd_addr_out,
  input  logic [DIST_WIDTH-1:0]               mem_rd_data_in,
  output logic                                mem_wr_en_out,
  output logic [ADDR_WIDTH-1:0]               mem_wr_addr_out,
  output logic [DIST_WIDTH-1:0]               mem_wr_data_out,
  output logic                                frontier_valid_out,
  output logic [ADDR_WIDTH-1:0]               frontier_id_out,
  input  logic                                frontier_ready_in,
  output logic                                busy_out,
  output logic                                done_out
);

  // Read counter runs 0..NUM_VIZINHOS: 0 is the node, k is neighbour slot k-1.
  localparam int CNT_W = $clog2(NUM_VIZINHOS + 1);

  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0]               node_id_reg;
  logic [ADDR_WIDTH*NUM_VIZINHOS-1:0]  vizinho_id_reg;
  logic [NUM_VIZINHOS-1:0]             vizinho_valid_reg;
  logic [CUSTO_WIDTH*NUM_VIZINHOS-1:0] custo_reg;

  logic [CNT_W-1:0] rd_cnt_reg;
  logic             cap_en_reg;
  logic [CNT_W-1:0] cap_idx_reg;

  logic [DIST_WIDTH-1:0]              dist_node_reg;
  logic [DIST_WIDTH-1:0]              dist_viz_reg [NUM_VIZINHOS];
  logic [DIST_WIDTH*NUM_VIZINHOS-1:0] dist_viz_packed;

  logic [NUM_VIZINHOS-1:0]            pending_reg;
  logic [DIST_WIDTH*NUM_VIZINHOS-1:0] nova_reg;

  logic [NUM_VIZINHOS-1:0]            update;
  logic [DIST_WIDTH*NUM_VIZINHOS-1:0] nova_dist;
  logic [NUM_VIZINHOS-1:0]            proc_mask;
  logic                               skip_relax;

  logic [ADDR_WIDTH-1:0] viz_id_arr [NUM_VIZINHOS];
  logic [DIST_WIDTH-1:0] nova_arr   [NUM_VIZINHOS];

  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [NUM_VIZINHOS-1:0] sel_onehot;
  logic [ADDR_WIDTH-1:0]   sel_id;
  logic [DIST_WIDTH-1:0]   sel_dist;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VIZINHOS; gi++) begin : g_unpack
      assign viz_id_arr[gi] = vizinho_id_reg[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign nova_arr[gi]   = nova_reg[gi*DIST_WIDTH +: DIST_WIDTH];
      assign dist_viz_packed[gi*DIST_WIDTH +: DIST_WIDTH] = dist_viz_reg[gi];
    end
  endgenerate

  process_node #(
    .DIST_WIDTH   (DIST_WIDTH),
    .CUSTO_WIDTH  (CUSTO_WIDTH),
    .NUM_VIZINHOS (NUM_VIZINHOS)
  ) u_process_node (
    .dist_node_in      (dist_node_reg),
    .custo_vizinhos_in (custo_reg),
    .dist_vizinhos_in  (dist_viz_packed),
    .update_out        (update),
    .nova_dist_out     (nova_dist)
  );

`ifdef RELAX_CTRL_INF_SKIP_EN
  // An unreachable node cannot improve anyone; the wrapping adder would
  // otherwise turn infinity + cost into a small bogus distance.
  assign skip_relax = (dist_node_reg == DIST_WIDTH'(dist_inf(DIST_WIDTH)));
`else
  assign skip_relax = 1'b0;
`endif

  assign proc_mask = skip_relax ? '0 : (update & vizinho_valid_reg);

  // Read address: node first, then every slot regardless of its valid bit.
  always_comb begin
    rd_addr = node_id_reg;
    for (int i = 0; i < NUM_VIZINHOS; i++) begin
      if (rd_cnt_reg == CNT_W'(i + 1)) rd_addr = viz_id_arr[i];
    end
  end

  // Lowest-index pending slot wins: scan downwards so the last hit is lowest.
  always_comb begin
    sel_onehot = '0;
    sel_id     = '0;
    sel_dist   = '0;
    for (int i = NUM_VIZINHOS - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        sel_id        = viz_id_arr[i];
        sel_dist      = nova_arr[i];
      end
    end
  end

  always_comb begin
    state_next         = state_reg;
    mem_rd_en_out      = 1'b0;
    mem_rd_addr_out    = '0;
    mem_wr_en_out      = 1'b0;
    mem_wr_addr_out    = '0;
    mem_wr_data_out    = '0;
    frontier_valid_out = 1'b0;
    frontier_id_out    = '0;
    busy_out           = (state_reg != ST_IDLE);
    done_out           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_in) state_next = ST_READ;
      end
      ST_READ: begin
        mem_rd_en_out   = 1'b1;
        mem_rd_addr_out = rd_addr;
        if (rd_cnt_reg == CNT_W'(NUM_VIZINHOS)) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        state_next = ST_PROC;
      end
      ST_PROC: begin
        state_next = (proc_mask != '0) ? ST_WRITE : ST_DONE;
      end
      ST_WRITE: begin
        frontier_valid_out = 1'b1;
        frontier_id_out    = sel_id;
        if (frontier_ready_in) begin
          mem_wr_en_out   = 1'b1;
          mem_wr_addr_out = sel_id;
          mem_wr_data_out = sel_dist;
          if ((pending_reg & ~sel_onehot) == '0) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done_out   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Control state: everything that must be cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pending_reg <= '0;
      rd_cnt_reg  <= '0;
      cap_en_reg  <= 1'b0;
      cap_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      // Data for a strobe arrives next cycle; remember which word it is.
      cap_en_reg  <= mem_rd_en_out;
      cap_idx_reg <= rd_cnt_reg;
      if (state_reg == ST_IDLE) begin
        rd_cnt_reg <= '0;
      end else if (state_reg == ST_READ) begin
        rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
      end
      if (state_reg == ST_PROC) begin
        pending_reg <= proc_mask;
      end else if (state_reg == ST_WRITE && frontier_ready_in) begin
        pending_reg <= pending_reg & ~sel_onehot;
      end
    end
  end

  // Datapath registers: only meaningful while the FSM qualifies them.
  always_ff @(posedge clk) begin
    if (state_reg == ST_IDLE && start_in) begin
      node_id_reg       <= node_id_in;
      vizinho_id_reg    <= vizinho_id_in;
      vizinho_valid_reg <= vizinho_valid_in;
      custo_reg         <= custo_vizinhos_in;
    end
    if (cap_en_reg) begin
      if (cap_idx_reg == '0) dist_node_reg <= mem_rd_data_in;
      for (int i = 0; i < NUM_VIZINHOS; i++) begin
        if (cap_idx_reg == CNT_W'(i + 1)) dist_viz_reg[i] <= mem_rd_data_in;
      end
    end
    if (state_reg == ST_PROC) nova_reg <= nova_dist;
  end

endmodule

// File: tb/tb_relax_ctrl.sv
// -----------------------------------------------------------------------------
// tb_relax_ctrl
// Directed bench for relax_ctrl with a behavioural distance memory.
// Stimulus pushes expected writes / frontier pushes into queues; a monitor
// pops and compares whenever the DUT writes or the frontier handshakes.
// -----------------------------------------------------------------------------
module tb_relax_ctrl;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int NV = 8;
  localparam int AW = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_in;
  logic [AW-1:0]      node_id_in;
  logic [AW*NV-1:0]   vizinho_id_in;
  logic [NV-1:0]      vizinho_valid_in;
  logic [CW*NV-1:0]   custo_vizinhos_in;
  logic               mem_rd_en_out;
  logic [AW-1:0]      mem_rd_addr_out;
  logic [DW-1:0]      mem_rd_data_in;
  logic               mem_wr_en_out;
  logic [AW-1:0]      mem_wr_addr_out;
  logic [DW-1:0]      mem_wr_data_out;
  logic               frontier_valid_out;
  logic [AW-1:0]      frontier_id_out;
  logic               frontier_ready_in;
  logic               busy_out;
  logic               done_out;

  always #5 clk = ~clk;

  relax_ctrl #(
    .DIST_WIDTH(DW), .CUSTO_WIDTH(CW), .NUM_VIZINHOS(NV), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .node_id_in(node_id_in),
    .vizinho_id_in(vizinho_id_in), .vizinho_valid_in(vizinho_valid_in),
    .custo_vizinhos_in(custo_vizinhos_in),
    .mem_rd_en_out(mem_rd_en_out), .mem_rd_addr_out(mem_rd_addr_out),
    .mem_rd_data_in(mem_rd_data_in),
    .mem_wr_en_out(mem_wr_en_out), .mem_wr_addr_out(mem_wr_addr_out),
    .mem_wr_data_out(mem_wr_data_out),
    .frontier_valid_out(frontier_valid_out), .frontier_id_out(frontier_id_out),
    .frontier_ready_in(frontier_ready_in),
    .busy_out(busy_out), .done_out(done_out)
  );

  // Distance memory: one-cycle read latency, plus a bench load port.
  logic [DW-1:0] mem [256];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  always @(posedge clk) begin
    if (mem_rd_en_out) mem_rd_data_in <= mem[mem_rd_addr_out];
    if (mem_wr_en_out) mem[mem_wr_addr_out] <= mem_wr_data_out;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr_q[$];
  logic [AW-1:0] exp_fr_q[$];
  wr_t           mon_wr;
  logic [AW-1:0] mon_fr;
  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int rd_seen = 0;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en_out) rd_seen++;
      if (done_out) done_seen++;
      if (mem_wr_en_out || (frontier_valid_out && frontier_ready_in)) begin
        checks++;
        if (mem_wr_en_out != (frontier_valid_out && frontier_ready_in)) begin
          errors++;
          $display("FAIL wr_vs_push: wr_en=%0b push=%0b, required equal",
                   mem_wr_en_out, frontier_valid_out && frontier_ready_in);
        end
      end
      if (mem_wr_en_out) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          errors++;
          $display("FAIL write: got addr=%0h data=%0h, required no write",
                   mem_wr_addr_out, mem_wr_data_out);
        end else begin
          mon_wr = exp_wr_q.pop_front();
          if (mem_wr_addr_out !== mon_wr.addr || mem_wr_data_out !== mon_wr.data) begin
            errors++;
            $display("FAIL write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                     mem_wr_addr_out, mem_wr_data_out, mon_wr.addr, mon_wr.data);
          end else begin
            $display("write addr=%0h data=%0h ok", mem_wr_addr_out, mem_wr_data_out);
          end
        end
      end
      if (frontier_valid_out && frontier_ready_in) begin
        checks++;
        if (exp_fr_q.size() == 0) begin
          errors++;
          $display("FAIL frontier: got id=%0h, required no push", frontier_id_out);
        end else begin
          mon_fr = exp_fr_q.pop_front();
          if (frontier_id_out !== mon_fr) begin
            errors++;
            $display("FAIL frontier: got id=%0h, required id=%0h", frontier_id_out, mon_fr);
          end else begin
            $display("frontier id=%0h ok", frontier_id_out);
          end
        end
      end
    end
  end

  // Request being assembled
  logic [AW-1:0] t_node;
  logic [AW-1:0] t_ids   [NV];
  logic [CW-1:0] t_costs [NV];
  logic [NV-1:0] t_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic drive_req();
    node_id_in = t_node;
    vizinho_valid_in = t_valid;
    for (int i = 0; i < NV; i++) begin
      vizinho_id_in[i*AW +: AW]     = t_ids[i];
      custo_vizinhos_in[i*CW +: CW] = t_costs[i];
    end
  endtask

  task automatic set_req(input logic [AW-1:0] node, input logic [NV-1:0] valid,
                         input logic [AW-1:0] id_base, input logic [CW-1:0] cost);
    t_node = node; t_valid = valid;
    for (int i = 0; i < NV; i++) begin
      t_ids[i]   = id_base + AW'(i);
      t_costs[i] = cost;
    end
  endtask

  // Start pulse sampled at edge E0 (cycle 0); returns #1 after E0.
  task automatic kick();
    @(negedge clk);
    drive_req();
    start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
  endtask

  // n = cycle index at which done_out is seen (start sampled at cycle 0).
  task automatic wait_done(output int n);
    n = 1;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done_out) break;
    end
    if (!done_out) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done_out, required pulse within 200 cycles");
    end
  endtask

  task automatic finish_seq(input string name);
    @(posedge clk); #1;
    chk({name, "_done_pulse_end"}, {31'd0, done_out}, 32'd0);
    chk({name, "_idle"}, {31'd0, busy_out}, 32'd0);
    chk({name, "_wr_q_empty"}, exp_wr_q.size(), 32'd0);
    chk({name, "_fr_q_empty"}, exp_fr_q.size(), 32'd0);
  endtask

  task automatic basic_setup();
    set_req(8'd1, 8'h03, 8'd20, 8'd0);
    t_ids[0] = 8'd10; t_ids[1] = 8'd11;
    t_costs[0] = 8'd2; t_costs[1] = 8'd3;
    load(8'd1, 8'd5); load(8'd10, 8'd10); load(8'd11, 8'd4);
  endtask

  initial begin
    int n;
    int k;
    int d0, r0;
    rst = 1'b1; start_in = 1'b0; frontier_ready_in = 1'b1; ld_en = 1'b0;
    ld_addr = '0; ld_data = '0; node_id_in = '0; vizinho_id_in = '0;
    vizinho_valid_in = '0; custo_vizinhos_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy_out}, 32'd0);
    chk("rst_done", {31'd0, done_out}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en_out}, 32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en_out}, 32'd0);
    chk("rst_fr_valid", {31'd0, frontier_valid_out}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single update: 5+2=7<10 written, 5+3=8 not < 4
    basic_setup();
    exp_wr_q.push_back('{addr: 8'd10, data: 8'd7});
    exp_fr_q.push_back(8'd10);
    kick(); wait_done(n);
    chk("basic_done_cycle", n, 32'd13);
    finish_seq("basic");
    chk("basic_mem10", {24'd0, mem[10]}, 32'd7);

    // Same with frontier stalled for 3 cycles
    load(8'd10, 8'd10);
    frontier_ready_in = 1'b0;
    exp_wr_q.push_back('{addr: 8'd10, data: 8'd7});
    exp_fr_q.push_back(8'd10);
    fork
      begin
        kick(); wait_done(n);
      end
      begin
        k = 0;
        while (!frontier_valid_out && k < 100) begin @(negedge clk); k++; end
        chk("stall_reached", {31'd0, frontier_valid_out}, 32'd1);
        for (int j = 0; j < 3; j++) begin
          if (j > 0) @(negedge clk);
          chk("stall_valid", {31'd0, frontier_valid_out}, 32'd1);
          chk("stall_id", {24'd0, frontier_id_out}, 32'd10);
          chk("stall_no_wr", {31'd0, mem_wr_en_out}, 32'd0);
        end
        @(posedge clk); #1 frontier_ready_in = 1'b1;
      end
    join
    finish_seq("stall");
    chk("stall_mem10", {24'd0, mem[10]}, 32'd7);

    // No updates: all neighbour distances 0, done at cycle NV+4
    set_req(8'd1, 8'hFF, 8'd50, 8'd1);
    for (int i = 0; i < NV; i++) load(8'd50 + AW'(i), 8'd0);
    kick(); wait_done(n);
    chk("noupd_done_cycle", n, 32'd12);
    finish_seq("noupd");

    // Repeated neighbour id: two writes in slot order, last wins
    set_req(8'd1, 8'h03, 8'd20, 8'd0);
    t_ids[0] = 8'd30; t_ids[1] = 8'd30;
    t_costs[0] = 8'd3; t_costs[1] = 8'd7;
    load(8'd30, 8'd50);
    exp_wr_q.push_back('{addr: 8'd30, data: 8'd8});
    exp_wr_q.push_back('{addr: 8'd30, data: 8'd12});
    exp_fr_q.push_back(8'd30); exp_fr_q.push_back(8'd30);
    kick(); wait_done(n);
    finish_seq("dup");
    chk("dup_mem30", {24'd0, mem[30]}, 32'd12);

    // Reset during WRITE with 3 pending slots
    set_req(8'd1, 8'h07, 8'd40, 8'd1);
    for (int i = 0; i < 3; i++) load(8'd40 + AW'(i), 8'd100);
    frontier_ready_in = 1'b0;
    kick();
    k = 0;
    while (!frontier_valid_out && k < 100) begin @(negedge clk); k++; end
    chk("rstw_reached", {31'd0, frontier_valid_out}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rstw_busy", {31'd0, busy_out}, 32'd0);
    chk("rstw_fr_valid", {31'd0, frontier_valid_out}, 32'd0);
    chk("rstw_fr_id", {24'd0, frontier_id_out}, 32'd0);
    chk("rstw_wr_en", {31'd0, mem_wr_en_out}, 32'd0);
    chk("rstw_rd_en", {31'd0, mem_rd_en_out}, 32'd0);
    frontier_ready_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstw_no_replay", {31'd0, busy_out}, 32'd0);
    chk("rstw_mem40", {24'd0, mem[40]}, 32'd100);
    basic_setup();
    exp_wr_q.push_back('{addr: 8'd10, data: 8'd7});
    exp_fr_q.push_back(8'd10);
    kick(); wait_done(n);
    finish_seq("after_rst");

    // Infinite node distance
    set_req(8'd2, 8'h01, 8'd20, 8'd0);
    t_ids[0] = 8'd60; t_costs[0] = 8'd2;
    load(8'd2, 8'hFF); load(8'd60, 8'd10);
`ifdef RELAX_CTRL_INF_SKIP_EN
    kick(); wait_done(n);
    chk("inf_done_cycle", n, 32'd12);
    finish_seq("inf");
    chk("inf_mem60", {24'd0, mem[60]}, 32'd10);
`else
    // 0xFF + 2 wraps to 0x01, which is below 10
    exp_wr_q.push_back('{addr: 8'd60, data: 8'd1});
    exp_fr_q.push_back(8'd60);
    kick(); wait_done(n);
    finish_seq("inf");
    chk("inf_mem60", {24'd0, mem[60]}, 32'd1);
`endif

    // start held high 20 cycles: sampled at cycles 0 and 13 only
    set_req(8'd1, 8'hFF, 8'd50, 8'd1);
    d0 = done_seen; r0 = rd_seen;
    @(negedge clk);
    drive_req();
    start_in = 1'b1;
    repeat (20) @(negedge clk);
    start_in = 1'b0;
    repeat (40) @(negedge clk);
    chk("hold_done_count", done_seen - d0, 32'd2);
    chk("hold_read_count", rd_seen - r0, 32'd18);
    chk("hold_idle", {31'd0, busy_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
